hardreg_pipe: RTL and testbench
===============================

Name: hardreg_pipe

Overview:
Parameterised elastic pipeline register: DEPTH stages of WIDTH-bit data, each stage with its own valid bit. Handshake is valid/ready on both ends. Bubbles collapse, so a stalled output does not block upstream while empty stages remain. Adds a synchronous flush and an occupancy count. It replaces single fixed-width clearable registers on datapaths that need back-pressure.

Parameters:
WIDTH, 8, data width in bits (>=1)
DEPTH, 4, number of register stages (>=1)
CNT_W, $clog2(DEPTH+1), occupancy count width (derived localparam, not overridable)

Ports:
clk  in  1  clock, rising edge
clr  in  1  reset, asynchronous, active-high
flush  in  1  synchronous clear of all stage valids
in_valid  in  1  upstream word present
in_data  in  WIDTH  upstream word
in_ready  out  1  pipe accepts in_data this cycle
out_valid  out  1  last stage holds a word
out_data  out  WIDTH  last stage data
out_ready  in  1  downstream accepts out_data this cycle
count  out  CNT_W  number of valid stages, 0..DEPTH

Behaviour:
- Reset: clr=1 asynchronously clears every stage valid to 0 and every stage data to 0. It holds while clr=1 and overrides flush and all handshakes. Resulting outputs: out_valid=0, out_data=0, count=0, in_ready=0. Stages are numbered 0 (input) to DEPTH-1 (output).
- Stage move rule: stage i "advances" when v[i]=1 and ready[i+1]=1. For the last stage, ready[DEPTH] = out_ready.
- Ready chain (combinational): ready[i] = !v[i] | ready[i+1].
- in_ready = ready[0] & !flush & !clr.
- Transfers:
  - Input transfer occurs on in_valid & in_ready.
  - Output transfer occurs on out_valid & out_ready.
  - out_valid = v[DEPTH-1]; out_data = d[DEPTH-1].
- Stage update on each clock edge when clr=0 and flush=0:
  - stage i loads d[i-1]/v[i-1] if ready[i]=1 (stage 0 loads in_data/in_valid&in_ready);
  - otherwise stage i holds its contents.
  - A stage's data register loads only when its incoming valid is 1; empty stages keep stale data.
- Latency: word accepted at edge t with an empty pipe and out_ready=1 gives out_valid=1 after edge t+DEPTH-1. Minimum latency is DEPTH cycles from in_valid to out_valid.
- Throughput: 1 word/cycle sustained when out_ready=1.
- Stall: with out_ready=0, the pipe fills to DEPTH words and then in_ready=0.
- Data and valid never change while out_valid=1 & out_ready=0.
- Full pipe with out_ready=1: all stages advance together and in_ready=1 in the same cycle (pass-through).
- Flush: on a clock edge with flush=1, all v[i] become 0 and count becomes 0.
  - Data registers hold.
  - in_ready=0 during the flush cycle, so no word is accepted.
  - An output transfer may still be signalled in that cycle; the consumer may take out_data, and the word is dropped from the pipe either way.
- count: registered. count_next = count + in_xfer - out_xfer (flush gives 0). It must always equal the popcount of v[] and never exceed DEPTH.
- DEPTH=1: degenerates to a single valid/data register with in_ready = !v | out_ready.
- No combinational path from in_valid or in_data to any output. There is a combinational path out_ready -> in_ready.

Decomposition:
- No shared package needed. CNT_W is a local derived constant.
- One sub-module: hardreg_stage (WIDTH parameter).
  - Ports: clk, clr, flush, up_valid, up_data, down_ready, v, d, ready.
  - Instantiated DEPTH times in a generate loop.
- Top level holds the ready-chain wiring and the count register.

Test Plan:
1. Reset mid-traffic: WIDTH=4, DEPTH=3, stream 0x1,0x2,0x3 with out_ready=0. Assert clr asynchronously mid-cycle -> out_valid=0, out_data=0x0, count=0 immediately, without waiting for a clock edge. in_ready returns to 1 on the first cycle after clr deasserts.
2. Latency/throughput: empty pipe, out_ready=1, push 0xA,0xB,0xC,0xD on consecutive cycles -> 0xA appears 3 cycles after its acceptance, then 0xB,0xC,0xD back-to-back. count stays 3 in steady state.
3. Back-pressure/bubble collapse: out_ready=0, push 0x5 then idle 2 cycles, then push 0x6,0x7 -> count=3, in_ready=0, out_data=0x5 held stable. Raise out_ready for 3 cycles -> outputs 0x5,0x6,0x7 in order with no loss or duplication.
4. Full pass-through: pipe full (count=3), in_valid=1 and out_ready=1 for 4 cycles with 0x8..0xB -> in_ready=1 every cycle and count stays 3.
5. Flush: count=2, assert flush for 1 cycle with in_valid=1, in_data=0xE -> in_ready=0 that cycle, count=0 next cycle, out_valid=0. 0xE never appears at the output.
6. DEPTH=1, WIDTH=8: alternate out_ready 1/0 with continuous input 0x01,0x02,... -> in_ready tracks !v | out_ready, output order is preserved, count toggles only between 0 and 1.

Source files
------------

// File: rtl/hardreg_stage.sv
`default_nettype none
// ============================================================================
// Module   : hardreg_stage
// Purpose  : One slot of the elastic pipeline register. Holds a valid bit and
//            a WIDTH-bit word; loads from upstream whenever it is empty or
//            its own word is leaving downstream in the same cycle.
// Ports    : clk        - clock, rising edge
//            clr        - asynchronous active-high reset (valid and data to 0)
//            flush      - synchronous clear of the valid bit (data holds)
//            up_valid   - word offered by the previous stage / input port
//            up_data    - word offered by the previous stage / input port
//            down_ready - next stage (or consumer) can take this word
//            v          - stage holds a word
//            d          - stage data (stale when v=0)
//            ready      - stage can take a word this cycle
// Revision : 1.0 - initial release
// ============================================================================
module hardreg_stage #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             flush,
  input  logic             up_valid,
  input  logic [WIDTH-1:0] up_data,
  input  logic             down_ready,
  output logic             v,
  output logic [WIDTH-1:0] d,
  output logic             ready
);

  logic             r_v;
  logic [WIDTH-1:0] r_d;

  // Empty slots are always ready, so bubbles collapse toward the output.
  assign ready = ~r_v | down_ready;
  assign v     = r_v;
  assign d     = r_d;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_v <= 1'b0;
      r_d <= '0;
    end else if (flush) begin
      r_v <= 1'b0;
    end else if (ready) begin
      r_v <= up_valid;
      // Data only moves with a valid word; empty slots keep stale data.
      if (up_valid) begin
        r_d <= up_data;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/hardreg_pipe.sv
`default_nettype none
// ============================================================================
// Module   : hardreg_pipe
// Purpose  : Elastic pipeline register of DEPTH stages with valid/ready on
//            both ends, collapsing bubbles, synchronous flush and a registered
//            occupancy count.
// Ports    : clk       - clock, rising edge
//            clr       - asynchronous active-high reset
//            flush     - synchronous clear of all stage valids
//            in_valid  - upstream word present
//            in_data   - upstream word
//            in_ready  - pipe accepts in_data this cycle
//            out_valid - last stage holds a word
//            out_data  - last stage data
//            out_ready - downstream accepts out_data this cycle
//            count     - number of valid stages, 0..DEPTH
// Revision : 1.0 - initial release
// ============================================================================
module hardreg_pipe #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [CNT_W-1:0] count
);

  logic [DEPTH-1:0] w_v;
  logic [WIDTH-1:0] w_d [DEPTH];
  // w_ready[i] is stage i's readiness; w_ready[DEPTH] is the consumer.
  logic [DEPTH:0]   w_ready;
  logic             w_in_xfer;
  logic             w_out_xfer;
  logic [CNT_W-1:0] r_count;

  assign w_ready[DEPTH] = out_ready;

  // clr is folded in so nothing is offered as accepted while in reset.
  assign in_ready   = w_ready[0] & ~flush & ~clr;
  assign w_in_xfer  = in_valid & in_ready;
  assign w_out_xfer = w_v[DEPTH-1] & out_ready;

  assign out_valid  = w_v[DEPTH-1];
  assign out_data   = w_d[DEPTH-1];
  assign count      = r_count;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic             w_up_valid;
    logic [WIDTH-1:0] w_up_data;

    if (i == 0) begin : g_head
      assign w_up_valid = w_in_xfer;
      assign w_up_data  = in_data;
    end else begin : g_body
      assign w_up_valid = w_v[i-1];
      assign w_up_data  = w_d[i-1];
    end

    hardreg_stage #(
      .WIDTH (WIDTH)
    ) u_stage (
      .clk        (clk),
      .clr        (clr),
      .flush      (flush),
      .up_valid   (w_up_valid),
      .up_data    (w_up_data),
      .down_ready (w_ready[i+1]),
      .v          (w_v[i]),
      .d          (w_d[i]),
      .ready      (w_ready[i])
    );
  end

  // Tracks popcount of the stage valids from the two port transfers.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_count <= '0;
    end else if (flush) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + CNT_W'(w_in_xfer) - CNT_W'(w_out_xfer);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hardreg_pipe.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_hardreg_pipe
// Purpose  : Self-checking bench for hardreg_pipe. Instance A is WIDTH=4,
//            DEPTH=3; instance B is WIDTH=8, DEPTH=1. A queue per instance
//            holds the words expected at the output in order.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hardreg_pipe;

  localparam int A_D = 3;
  localparam int B_D = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Instance A
  logic       a_clr = 1'b1, a_flush = 1'b0, a_in_valid = 1'b0, a_out_ready = 1'b0;
  logic [3:0] a_in_data = 4'h0;
  logic       a_in_ready, a_out_valid;
  logic [3:0] a_out_data;
  logic [1:0] a_count;

  // Instance B
  logic       b_clr = 1'b1, b_flush = 1'b0, b_in_valid = 1'b0, b_out_ready = 1'b0;
  logic [7:0] b_in_data = 8'h0;
  logic       b_in_ready, b_out_valid;
  logic [7:0] b_out_data;
  logic [0:0] b_count;

  logic [3:0] aq[$];
  logic [7:0] bq[$];

  hardreg_pipe #(.WIDTH(4), .DEPTH(A_D)) u_dut_a (
    .clk(clk), .clr(a_clr), .flush(a_flush),
    .in_valid(a_in_valid), .in_data(a_in_data), .in_ready(a_in_ready),
    .out_valid(a_out_valid), .out_data(a_out_data), .out_ready(a_out_ready),
    .count(a_count)
  );

  hardreg_pipe #(.WIDTH(8), .DEPTH(B_D)) u_dut_b (
    .clk(clk), .clr(b_clr), .flush(b_flush),
    .in_valid(b_in_valid), .in_data(b_in_data), .in_ready(b_in_ready),
    .out_valid(b_out_valid), .out_data(b_out_data), .out_ready(b_out_ready),
    .count(b_count)
  );

  always @(posedge a_clr) aq.delete();
  always @(posedge b_clr) bq.delete();

  // Scoreboard A: sampled mid-cycle, describing the transfers of the next edge.
  always @(negedge clk) begin
    if (!a_clr) begin
      checks++;
      if (a_count !== 2'(aq.size())) begin
        errors++; $display("FAIL a_count_track: got %0d expected %0d", a_count, aq.size());
      end
      checks++;
      if (a_in_ready !== (!a_flush && !(aq.size() == A_D && !a_out_ready))) begin
        errors++; $display("FAIL a_in_ready_track: got %b expected %b", a_in_ready,
                           (!a_flush && !(aq.size() == A_D && !a_out_ready)));
      end
      if (a_out_valid && a_out_ready) begin
        checks++;
        if (aq.size() == 0) begin
          errors++; $display("FAIL a_unexpected_out: got %h expected no word", a_out_data);
        end else begin
          logic [3:0] e;
          e = aq.pop_front();
          if (a_out_data !== e) begin
            errors++; $display("FAIL a_out_order: got %h expected %h", a_out_data, e);
          end
        end
      end
      if (a_flush) aq.delete();
      else if (a_in_valid && a_in_ready) aq.push_back(a_in_data);
    end
  end

  // Scoreboard B
  always @(negedge clk) begin
    if (!b_clr) begin
      checks++;
      if (b_count !== 1'(bq.size())) begin
        errors++; $display("FAIL b_count_track: got %0d expected %0d", b_count, bq.size());
      end
      if (b_out_valid && b_out_ready) begin
        checks++;
        if (bq.size() == 0) begin
          errors++; $display("FAIL b_unexpected_out: got %h expected no word", b_out_data);
        end else begin
          logic [7:0] e;
          e = bq.pop_front();
          if (b_out_data !== e) begin
            errors++; $display("FAIL b_out_order: got %h expected %h", b_out_data, e);
          end
        end
      end
      if (b_flush) bq.delete();
      else if (b_in_valid && b_in_ready) bq.push_back(b_in_data);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    step();
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b expected 0", a_out_valid); end
    checks++; if (a_out_data !== 4'h0) begin errors++; $display("FAIL rst_out_data: got %h expected 0", a_out_data); end
    checks++; if (a_count !== 2'd0) begin errors++; $display("FAIL rst_count: got %0d expected 0", a_count); end
    checks++; if (a_in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready: got %b expected 0", a_in_ready); end
    checks++; if (b_in_ready !== 1'b0) begin errors++; $display("FAIL rst_b_in_ready: got %b expected 0", b_in_ready); end
    a_clr = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      a_in_valid = 1'b1; a_in_data = 4'(i);
      step();
    end
    a_in_valid = 1'b0;
    #1;
    checks++; if (a_count !== 2'd3) begin errors++; $display("FAIL rst_prefill_count: got %0d expected 3", a_count); end
    checks++; if (a_out_data !== 4'h1) begin errors++; $display("FAIL rst_prefill_data: got %h expected 1", a_out_data); end
    #1 a_clr = 1'b1;
    #1;
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL rst_async_valid: got %b expected 0", a_out_valid); end
    checks++; if (a_out_data !== 4'h0) begin errors++; $display("FAIL rst_async_data: got %h expected 0", a_out_data); end
    checks++; if (a_count !== 2'd0) begin errors++; $display("FAIL rst_async_count: got %0d expected 0", a_count); end
    // Held reset overrides handshakes.
    step();
    a_in_valid = 1'b1; a_in_data = 4'hF;
    step();
    checks++; if (a_out_valid !== 1'b0 || a_count !== 2'd0) begin
      errors++; $display("FAIL rst_hold: got valid %b count %0d expected 0 0", a_out_valid, a_count);
    end
    a_in_valid = 1'b0;
    a_clr = 1'b0;
    #1;
    checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready: got %b expected 1", a_in_ready); end
  endtask

  task automatic test_latency();
    logic [3:0] vals [4];
    vals = '{4'hA, 4'hB, 4'hC, 4'hD};
    a_out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      a_in_valid = (c < 4);
      a_in_data  = (c < 4) ? vals[c] : 4'h0;
      #1;
      if (c >= 3 && c < 7) begin
        checks++;
        if (a_out_valid !== 1'b1 || a_out_data !== vals[c-3]) begin
          errors++; $display("FAIL lat_out c%0d: got valid %b data %h expected 1 %h", c, a_out_valid, a_out_data, vals[c-3]);
        end
      end else begin
        checks++;
        if (a_out_valid !== 1'b0) begin errors++; $display("FAIL lat_idle c%0d: got valid %b expected 0", c, a_out_valid); end
      end
      if (c == 3 || c == 4) begin
        checks++;
        if (a_count !== 2'd3) begin errors++; $display("FAIL lat_count c%0d: got %0d expected 3", c, a_count); end
      end
      step();
    end
    a_in_valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic       iv [10];
    logic [3:0] id [10];
    logic       orr[10];
    iv  = '{1, 0, 0, 1, 1, 1, 0, 0, 0, 0};
    id  = '{4'h5, 4'h0, 4'h0, 4'h6, 4'h7, 4'h9, 4'h0, 4'h0, 4'h0, 4'h0};
    orr = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 0};
    for (int c = 0; c < 10; c++) begin
      a_in_valid = iv[c]; a_in_data = id[c]; a_out_ready = orr[c];
      #1;
      if (c >= 3 && c <= 6) begin
        checks++;
        if (a_out_valid !== 1'b1 || a_out_data !== 4'h5) begin
          errors++; $display("FAIL bp_hold c%0d: got valid %b data %h expected 1 5", c, a_out_valid, a_out_data);
        end
      end
      if (c == 5) begin
        checks++;
        if (a_count !== 2'd3 || a_in_ready !== 1'b0) begin
          errors++; $display("FAIL bp_full: got count %0d in_ready %b expected 3 0", a_count, a_in_ready);
        end
      end
      if (c == 7 || c == 8) begin
        checks++;
        if (a_out_data !== ((c == 7) ? 4'h6 : 4'h7)) begin
          errors++; $display("FAIL bp_drain c%0d: got %h expected %h", c, a_out_data, (c == 7) ? 4'h6 : 4'h7);
        end
      end
      if (c == 9) begin
        checks++;
        if (a_out_valid !== 1'b0 || a_count !== 2'd0) begin
          errors++; $display("FAIL bp_empty: got valid %b count %0d expected 0 0", a_out_valid, a_count);
        end
      end
      step();
    end
    a_in_valid = 1'b0; a_out_ready = 1'b0;
  endtask

  task automatic test_pass_through();
    logic [3:0] outs [7];
    outs = '{4'h1, 4'h2, 4'h3, 4'h8, 4'h9, 4'hA, 4'hB};
    for (int c = 0; c < 11; c++) begin
      a_in_valid  = (c < 7);
      a_in_data   = (c < 3) ? 4'(c + 1) : 4'(c + 5);
      a_out_ready = (c >= 3);
      #1;
      if (c >= 3 && c <= 6) begin
        checks++;
        if (a_in_ready !== 1'b1 || a_count !== 2'd3) begin
          errors++; $display("FAIL pt_flow c%0d: got in_ready %b count %0d expected 1 3", c, a_in_ready, a_count);
        end
      end
      if (c >= 3 && c <= 9) begin
        checks++;
        if (a_out_valid !== 1'b1 || a_out_data !== outs[c-3]) begin
          errors++; $display("FAIL pt_out c%0d: got valid %b data %h expected 1 %h", c, a_out_valid, a_out_data, outs[c-3]);
        end
      end
      if (c == 7) a_in_valid = 1'b0;
      if (c == 10) begin
        checks++;
        if (a_out_valid !== 1'b0 || a_count !== 2'd0) begin
          errors++; $display("FAIL pt_empty: got valid %b count %0d expected 0 0", a_out_valid, a_count);
        end
      end
      step();
    end
    a_in_valid = 1'b0; a_out_ready = 1'b0;
  endtask

  task automatic test_flush();
    a_out_ready = 1'b0;
    for (int c = 0; c < 8; c++) begin
      a_flush     = (c == 2);
      a_in_valid  = (c <= 2);
      a_in_data   = (c == 2) ? 4'hE : 4'(c + 1);
      a_out_ready = (c >= 3);
      #1;
      if (c == 2) begin
        checks++;
        if (a_count !== 2'd2 || a_in_ready !== 1'b0) begin
          errors++; $display("FAIL fl_cycle: got count %0d in_ready %b expected 2 0", a_count, a_in_ready);
        end
      end
      if (c >= 3) begin
        checks++;
        if (a_out_valid !== 1'b0 || a_count !== 2'd0) begin
          errors++; $display("FAIL fl_after c%0d: got valid %b data %h count %0d expected 0 0", c, a_out_valid, a_out_data, a_count);
        end
      end
      step();
    end
    a_flush = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b0;
  endtask

  task automatic test_depth1();
    logic       mv;
    logic       exp_ir;
    logic [7:0] nd;
    mv = 1'b0; nd = 8'h01;
    b_clr = 1'b0;
    for (int c = 0; c < 12; c++) begin
      b_in_valid = 1'b1; b_in_data = nd; b_out_ready = (c % 2 == 0);
      #1;
      exp_ir = !mv || b_out_ready;
      checks++;
      if (b_in_ready !== exp_ir) begin
        errors++; $display("FAIL d1_in_ready c%0d: got %b expected %b", c, b_in_ready, exp_ir);
      end
      checks++;
      if (b_out_valid !== mv || b_count !== mv) begin
        errors++; $display("FAIL d1_state c%0d: got valid %b count %0d expected %b", c, b_out_valid, b_count, mv);
      end
      mv = exp_ir ? 1'b1 : (mv && !b_out_ready);
      if (exp_ir) nd = nd + 8'h01;
      step();
    end
    b_in_valid = 1'b0; b_out_ready = 1'b1;
    step();
    checks++;
    if (b_out_valid !== 1'b0 || b_count !== 1'b0) begin
      errors++; $display("FAIL d1_drain: got valid %b count %0d expected 0 0", b_out_valid, b_count);
    end
    b_out_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_latency();
    test_back_to_back();
    test_pass_through();
    test_flush();
    test_depth1();
    repeat (3) step();
    checks++;
    if (aq.size() != 0 || bq.size() != 0) begin
      errors++; $display("FAIL words_lost: got %0d/%0d pending expected 0/0", aq.size(), bq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
